// File: rtl/sdram_read.sv
// SDRAM burst-read engine: arbitrates for the bus, opens a row, streams BL=4 READs
// from a linear bank/row/column pointer and returns captured words to the read cache.
module sdram_read #(
    parameter int CAS_LAT = 3,
    parameter int DQ_W    = 16
) (
    input  logic            sysclk_100M,
    input  logic            rst_n,
    output logic            arbit_read_req,
    input  logic            arbit_read_ack,
    output logic            read_end,
    output logic            burst_end,
    input  logic            refresh_req,
    output logic [3:0]      cmd_reg,
    output logic [12:0]     sdram_addr,
    output logic [1:0]      sdram_bank_addr,
    input  logic [DQ_W-1:0] sdram_dq,
    input  logic            read_ready,
    output logic [DQ_W-1:0] rd_data,
    output logic            rd_data_valid
);

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_REQ    = 5'b00010,
        S_ACT    = 5'b00100,
        S_READ   = 5'b01000,
        S_PRECHG = 5'b10000
    } state_t;

    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_READ = 4'b0101;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_NOP  = 4'b0111;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [1:0]        burst_cnt_q, burst_cnt_d;
    logic [6:0]        col_p_q, col_p_d;
    logic [14:0]       bank_row_q, bank_row_d;
    logic              refresh_pend_q, refresh_pend_d;
    logic              end_pend_q, end_pend_d;
    logic [CAS_LAT:0]  valid_pipe_q, valid_pipe_d;
    logic [DQ_W-1:0]   rd_data_q, rd_data_d;
    logic              row_end;

    assign burst_end     = (burst_cnt_q == 2'd3);
    assign read_end      = burst_end && !read_ready;
    assign row_end       = (col_p_q == 7'd127);
    assign rd_data       = rd_data_q;
    assign rd_data_valid = valid_pipe_q[CAS_LAT];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d         = state_q;
        phase_d         = 1'b0;
        burst_cnt_d     = burst_cnt_q;
        col_p_d         = col_p_q;
        bank_row_d      = bank_row_q;
        refresh_pend_d  = refresh_pend_q;
        end_pend_d      = end_pend_q;
        arbit_read_req  = 1'b0;
        cmd_reg         = CMD_NOP;
        sdram_addr      = 13'h0000;
        sdram_bank_addr = bank_row_q[14:13];

        unique case (state_q)
            S_IDLE: begin
                if (read_ready) state_d = S_REQ;
            end
            S_REQ: begin
                arbit_read_req = 1'b1;
                if (arbit_read_ack) state_d = S_ACT;
            end
            S_ACT: begin
                if (!phase_q) begin
                    cmd_reg    = CMD_ACT;
                    sdram_addr = bank_row_q[12:0];
                    phase_d    = 1'b1;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                burst_cnt_d = burst_cnt_q + 2'd1;
                if (burst_cnt_q == 2'd0) begin
                    cmd_reg    = CMD_READ;
                    sdram_addr = {4'b0000, col_p_q, 2'b00};
                end
                // The column pointer advances once per completed burst; the final
                // burst of a row also carries into {bank,row}.
                if (burst_end) begin
                    col_p_d        = col_p_q + 7'd1;
                    refresh_pend_d = refresh_req;
                    end_pend_d     = read_end;
                    if (row_end) bank_row_d = bank_row_q + 15'd1;
                    if (refresh_req || read_end || row_end) state_d = S_PRECHG;
                end
            end
            S_PRECHG: begin
                if (!phase_q) begin
                    cmd_reg    = CMD_PRE;
                    sdram_addr = 13'h0400;
                    phase_d    = 1'b1;
                end else if (refresh_pend_q) begin
                    state_d = S_REQ;
                end else if (end_pend_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ACT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture is decoupled from the FSM so a PRECHARGE never truncates returning data.
    always_comb begin
        valid_pipe_d = {valid_pipe_q[CAS_LAT-1:0], (state_q == S_READ)};
        rd_data_d    = sdram_dq;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            phase_q        <= 1'b0;
            burst_cnt_q    <= 2'd0;
            col_p_q        <= 7'd0;
            bank_row_q     <= 15'd0;
            refresh_pend_q <= 1'b0;
            end_pend_q     <= 1'b0;
            valid_pipe_q   <= '0;
            rd_data_q      <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            burst_cnt_q    <= burst_cnt_d;
            col_p_q        <= col_p_d;
            bank_row_q     <= bank_row_d;
            refresh_pend_q <= refresh_pend_d;
            end_pend_q     <= end_pend_d;
            valid_pipe_q   <= valid_pipe_d;
            rd_data_q      <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: one CAS_LAT=3 and one CAS_LAT=2 instance share stimulus.
module tb_sdram_read;

    localparam int DQ_W = 16;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] NOP = 4'b0111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, read_ready, ack, refresh_req;
    logic [DQ_W-1:0] dq, dq_at_edge;

    logic            a_req, a_read_end, a_burst_end, a_valid;
    logic [3:0]      a_cmd;
    logic [12:0]     a_addr;
    logic [1:0]      a_ba;
    logic [DQ_W-1:0] a_data;
    logic            b_req, b_read_end, b_burst_end, b_valid;
    logic [3:0]      b_cmd;
    logic [12:0]     b_addr;
    logic [1:0]      b_ba;
    logic [DQ_W-1:0] b_data;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_read #(.CAS_LAT(3), .DQ_W(DQ_W)) dut_a (
        .sysclk_100M(clk), .rst_n(rst_n), .arbit_read_req(a_req), .arbit_read_ack(ack),
        .read_end(a_read_end), .burst_end(a_burst_end), .refresh_req(refresh_req),
        .cmd_reg(a_cmd), .sdram_addr(a_addr), .sdram_bank_addr(a_ba), .sdram_dq(dq),
        .read_ready(read_ready), .rd_data(a_data), .rd_data_valid(a_valid)
    );

    sdram_read #(.CAS_LAT(2), .DQ_W(DQ_W)) dut_b (
        .sysclk_100M(clk), .rst_n(rst_n), .arbit_read_req(b_req), .arbit_read_ack(ack),
        .read_end(b_read_end), .burst_end(b_burst_end), .refresh_req(refresh_req),
        .cmd_reg(b_cmd), .sdram_addr(b_addr), .sdram_bank_addr(b_ba), .sdram_dq(dq),
        .read_ready(read_ready), .rd_data(b_data), .rd_data_valid(b_valid)
    );

    // One clock: remember the dq value the DUT registers, then move dq off the edge.
    task automatic cyc();
        @(posedge clk);
        dq_at_edge = dq;
        #2;
        dq = dq + 16'h1357;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; read_ready = 1'b0; ack = 1'b0; refresh_req = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for the request, grants 2 cycles later; returns in the ACT cycle.
    task automatic grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            cyc();
            if (a_req === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            cyc(); cyc();
            ack = 1'b1;
            cyc();
            ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; read_ready = 1'b0; ack = 1'b0; refresh_req = 1'b0; dq = 16'hA5A5;
        cyc(); cyc();
        n_checks++; if (a_cmd !== NOP) begin n_fail++; $display("FAIL reset_cmd: got %b want %b", a_cmd, NOP); end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", a_req); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_checks++; if (a_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", a_data); end
        n_checks++; if (a_burst_end !== 1'b0) begin n_fail++; $display("FAIL reset_burst_end: got %b want 0", a_burst_end); end
        n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_cl2: got %b want 0", b_valid); end
        rst_n = 1'b1;
        cyc();
        n_checks++; if (a_req !== 1'b0 || a_cmd !== NOP) begin n_fail++; $display("FAIL idle_no_ready: req %b cmd %b want 0/%b", a_req, a_cmd, NOP); end
    endtask

    task automatic test_single_burst();
        bit ok;
        logic [3:0] exp_cmd;
        logic exp_v;
        do_reset();
        read_ready = 1'b1;
        grant(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL s1_req_timeout: got no request want request"); end
        n_checks++; if (a_cmd !== ACT || a_addr !== 13'h0 || a_ba !== 2'd0) begin n_fail++; $display("FAIL s1_act: got %b/%h/%h want %b/000/0", a_cmd, a_addr, a_ba, ACT); end
        cyc();
        n_checks++; if (a_cmd !== NOP) begin n_fail++; $display("FAIL s1_trcd: got %b want %b", a_cmd, NOP); end
        cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h0) begin n_fail++; $display("FAIL s1_read: got %b/%h want %b/000", a_cmd, a_addr, RD); end
        read_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            exp_cmd = (k == 4) ? PRE : NOP;
            exp_v   = (k >= 4 && k <= 7);
            n_checks++; if (a_cmd !== exp_cmd) begin n_fail++; $display("FAIL s1_cmd k=%0d: got %b want %b", k, a_cmd, exp_cmd); end
            n_checks++; if (a_valid !== exp_v) begin n_fail++; $display("FAIL s1_valid k=%0d: got %b want %b", k, a_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (a_data !== dq_at_edge) begin n_fail++; $display("FAIL s1_data k=%0d: got %h want %h", k, a_data, dq_at_edge); end
            end
            if (k == 4) begin
                n_checks++; if (a_addr !== 13'h0400) begin n_fail++; $display("FAIL s1_pre_a10: got %h want 0400", a_addr); end
            end
            n_checks++; if (a_read_end !== (k == 3)) begin n_fail++; $display("FAIL s1_read_end k=%0d: got %b", k, a_read_end); end
        end
    endtask

    task automatic test_multi_burst();
        bit ok;
        logic [3:0] exp_cmd;
        logic exp_v;
        do_reset();
        read_ready = 1'b1;
        grant(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL s2_req_timeout: got no request want request"); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h000) begin n_fail++; $display("FAIL s2_read0: got %b/%h want %b/000", a_cmd, a_addr, RD); end
        for (int k = 1; k <= 17; k++) begin
            cyc();
            exp_cmd = (k == 4 || k == 8) ? RD : (k == 12) ? PRE : NOP;
            exp_v   = (k >= 4 && k <= 15);
            n_checks++; if (a_cmd !== exp_cmd) begin n_fail++; $display("FAIL s2_cmd k=%0d: got %b want %b", k, a_cmd, exp_cmd); end
            if (k == 4 || k == 8) begin
                n_checks++; if (a_addr !== 13'(k)) begin n_fail++; $display("FAIL s2_col k=%0d: got %h want %h", k, a_addr, 13'(k)); end
            end
            if (k == 12) begin
                n_checks++; if (a_addr !== 13'h0400) begin n_fail++; $display("FAIL s2_pre_a10: got %h want 0400", a_addr); end
            end
            n_checks++; if (a_valid !== exp_v) begin n_fail++; $display("FAIL s2_valid k=%0d: got %b want %b", k, a_valid, exp_v); end
            n_checks++; if (a_burst_end !== (k % 4 == 3 && k <= 11)) begin n_fail++; $display("FAIL s2_burst_end k=%0d: got %b", k, a_burst_end); end
            n_checks++; if (a_read_end !== (k == 11)) begin n_fail++; $display("FAIL s2_read_end k=%0d: got %b", k, a_read_end); end
            if (k == 8) read_ready = 1'b0;
        end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL s2_idle: req %b want 0", a_req); end
    endtask

    // Continues from col 3 left by the previous scenario.
    task automatic test_refresh();
        bit ok;
        read_ready = 1'b1;
        grant(ok);
        n_checks++; if (!ok || a_cmd !== ACT || a_addr !== 13'h0) begin n_fail++; $display("FAIL s3_act: ok %b got %b/%h want %b/000", ok, a_cmd, a_addr, ACT); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h00C) begin n_fail++; $display("FAIL s3_read: got %b/%h want %b/00c", a_cmd, a_addr, RD); end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) refresh_req = 1'b1;
            if (k == 3) begin
                n_checks++; if (a_burst_end !== 1'b1 || a_read_end !== 1'b0) begin n_fail++; $display("FAIL s3_end_flags: got %b/%b want 1/0", a_burst_end, a_read_end); end
            end
            if (k == 4) begin
                n_checks++; if (a_cmd !== PRE || a_addr !== 13'h0400) begin n_fail++; $display("FAIL s3_pre: got %b/%h want %b/0400", a_cmd, a_addr, PRE); end
                refresh_req = 1'b0;
            end
            if (k == 5) begin
                n_checks++; if (a_cmd !== NOP) begin n_fail++; $display("FAIL s3_trp: got %b want %b", a_cmd, NOP); end
            end
        end
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL s3_rereq: req %b want 1", a_req); end
        grant(ok);
        n_checks++; if (!ok || a_cmd !== ACT || a_addr !== 13'h0) begin n_fail++; $display("FAIL s3_reopen: ok %b got %b/%h want %b/000", ok, a_cmd, a_addr, ACT); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h010) begin n_fail++; $display("FAIL s3_resume: got %b/%h want %b/010", a_cmd, a_addr, RD); end
        read_ready = 1'b0;
        for (int k = 1; k <= 6; k++) cyc();
        n_checks++; if (a_req !== 1'b0 || a_cmd !== NOP) begin n_fail++; $display("FAIL s3_idle: req %b cmd %b want 0/%b", a_req, a_cmd, NOP); end
    endtask

    // Refresh and read_ready low at the same burst end: refresh wins, engine re-requests.
    task automatic test_refresh_vs_end();
        bit ok;
        read_ready = 1'b1;
        grant(ok);
        cyc(); cyc();
        n_checks++; if (!ok || a_cmd !== RD || a_addr !== 13'h014) begin n_fail++; $display("FAIL s3b_read: ok %b got %b/%h want %b/014", ok, a_cmd, a_addr, RD); end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) begin refresh_req = 1'b1; read_ready = 1'b0; end
            if (k == 3) begin
                n_checks++; if (a_read_end !== 1'b1) begin n_fail++; $display("FAIL s3b_read_end: got %b want 1", a_read_end); end
            end
            if (k == 4) begin
                n_checks++; if (a_cmd !== PRE) begin n_fail++; $display("FAIL s3b_pre: got %b want %b", a_cmd, PRE); end
                refresh_req = 1'b0;
            end
        end
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL s3b_refresh_wins: req %b want 1", a_req); end
        grant(ok);
        cyc(); cyc();
        n_checks++; if (!ok || a_cmd !== RD || a_addr !== 13'h018) begin n_fail++; $display("FAIL s3b_resume: ok %b got %b/%h want %b/018", ok, a_cmd, a_addr, RD); end
        for (int k = 1; k <= 6; k++) cyc();
        n_checks++; if (a_req !== 1'b0 || a_cmd !== NOP) begin n_fail++; $display("FAIL s3b_idle: req %b cmd %b want 0/%b", a_req, a_cmd, NOP); end
    endtask

    task automatic test_row_end();
        bit ok;
        do_reset();
        read_ready = 1'b1;
        grant(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL s4_req_timeout: got no request want request"); end
        cyc();
        for (int j = 0; j < 128; j++) begin
            cyc();
            n_checks++; if (a_cmd !== RD || a_addr !== 13'(j * 4)) begin n_fail++; $display("FAIL s4_col j=%0d: got %b/%h want %b/%h", j, a_cmd, a_addr, RD, 13'(j * 4)); end
            cyc(); cyc(); cyc();
        end
        n_checks++; if (a_burst_end !== 1'b1 || a_read_end !== 1'b0) begin n_fail++; $display("FAIL s4_last_burst: got %b/%b want 1/0", a_burst_end, a_read_end); end
        cyc();
        n_checks++; if (a_cmd !== PRE || a_addr !== 13'h0400) begin n_fail++; $display("FAIL s4_pre: got %b/%h want %b/0400", a_cmd, a_addr, PRE); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== ACT || a_addr !== 13'h0001 || a_ba !== 2'd0) begin n_fail++; $display("FAIL s4_next_row: got %b/%h/%h want %b/0001/0", a_cmd, a_addr, a_ba, ACT); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h000) begin n_fail++; $display("FAIL s4_col_wrap: got %b/%h want %b/000", a_cmd, a_addr, RD); end
        read_ready = 1'b0;
        for (int k = 1; k <= 6; k++) cyc();
        n_checks++; if (a_req !== 1'b0 || a_cmd !== NOP) begin n_fail++; $display("FAIL s4_idle: req %b cmd %b want 0/%b", a_req, a_cmd, NOP); end
    endtask

    // Pointer is row 1 / col 1 on entry; reset at burst_cnt 2 must zero it.
    task automatic test_reset_mid();
        bit ok;
        read_ready = 1'b1;
        grant(ok);
        n_checks++; if (!ok || a_addr !== 13'h0001) begin n_fail++; $display("FAIL s5_act: ok %b addr %h want 0001", ok, a_addr); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h004) begin n_fail++; $display("FAIL s5_read: got %b/%h want %b/004", a_cmd, a_addr, RD); end
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_cmd !== NOP || a_req !== 1'b0) begin n_fail++; $display("FAIL s5_rst_cmd: cmd %b req %b want %b/0", a_cmd, a_req, NOP); end
        n_checks++; if (a_data !== '0 || a_valid !== 1'b0 || a_burst_end !== 1'b0) begin n_fail++; $display("FAIL s5_rst_clear: data %h valid %b be %b want 0", a_data, a_valid, a_burst_end); end
        cyc();
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_req !== 1'b0 || a_cmd !== NOP || a_valid !== 1'b0) begin n_fail++; $display("FAIL s5_release_idle: req %b cmd %b valid %b", a_req, a_cmd, a_valid); end
        cyc();
        n_checks++; if (a_req !== 1'b1 || a_valid !== 1'b0) begin n_fail++; $display("FAIL s5_stale_capture: req %b valid %b want 1/0", a_req, a_valid); end
        grant(ok);
        n_checks++; if (!ok || a_cmd !== ACT || a_addr !== 13'h0) begin n_fail++; $display("FAIL s5_ptr_cleared: ok %b got %b/%h want %b/000", ok, a_cmd, a_addr, ACT); end
        cyc(); cyc();
        n_checks++; if (a_cmd !== RD || a_addr !== 13'h000) begin n_fail++; $display("FAIL s5_read0: got %b/%h want %b/000", a_cmd, a_addr, RD); end
        read_ready = 1'b0;
        for (int k = 1; k <= 8; k++) cyc();
    endtask

    task automatic test_cas_lat2();
        bit ok;
        logic exp_v;
        do_reset();
        read_ready = 1'b1;
        grant(ok);
        cyc(); cyc();
        n_checks++; if (!ok || b_cmd !== RD || b_addr !== 13'h000) begin n_fail++; $display("FAIL s6_read: ok %b got %b/%h want %b/000", ok, b_cmd, b_addr, RD); end
        read_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            exp_v = (k >= 3 && k <= 6);
            n_checks++; if (b_valid !== exp_v) begin n_fail++; $display("FAIL s6_valid k=%0d: got %b want %b", k, b_valid, exp_v); end
            if (exp_v) begin
                n_checks++; if (b_data !== dq_at_edge) begin n_fail++; $display("FAIL s6_data k=%0d: got %h want %h", k, b_data, dq_at_edge); end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_multi_burst();
        test_refresh();
        test_refresh_vs_end();
        test_row_end();
        test_reset_mid();
        test_cas_lat2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
